// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
// Imported by the arbiter top and its pick sub-module.
package rr_arbiter4_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int unsigned     CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4_pick.sv
// Rotating priority pick: returns the first set bit of vec, scanning from start upward mod 4.
module rr_pick4 (
    input  logic [3:0] vec,
    input  logic [1:0] start,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] pos;

    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            pos = start + 2'(i);
            if (!any && vec[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter sharing a 1-bit channel, with a hold limit
// that only applies while another requester is waiting.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned MAXHOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       valid,
    output logic       dout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAXHOLD - 1);

    state_e           state_q;
    logic [1:0]       owner_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0] owner_nx;
    logic [3:0] others;
    logic       release_c;
    logic [1:0] idle_idx;
    logic       idle_any;
    logic [1:0] hand_idx;
    logic       hand_any;

    assign owner_nx  = owner_q + 2'd1;
    assign others    = req & ~onehot4(owner_q);
    assign release_c = !req[owner_q] || ((cnt_q == HOLD_LAST) && (others != 4'b0000));

    rr_pick4 u_pick_idle (
        .vec   (req),
        .start (ptr_q),
        .idx   (idle_idx),
        .any   (idle_any)
    );

    // Handoff search starts just past the current owner, so a forced release never regrants it.
    rr_pick4 u_pick_hand (
        .vec   (others),
        .start (owner_nx),
        .idx   (hand_idx),
        .any   (hand_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (idle_any) begin
                        owner_q <= idle_idx;
                        cnt_q   <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        ptr_q <= owner_nx;
                        if (hand_any) begin
                            owner_q <= hand_idx;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [3:0] dec;
    logic       sel_bit;

    always_comb begin
        dec = '0;
        case (owner_q)
            2'd0:    dec = 4'b0001;
            2'd1:    dec = 4'b0010;
            2'd2:    dec = 4'b0100;
            default: dec = 4'b1000;
        endcase
    end

    always_comb begin
        sel_bit = 1'b0;
        case (owner_q)
            2'd0:    sel_bit = din[0];
            2'd1:    sel_bit = din[1];
            2'd2:    sel_bit = din[2];
            default: sel_bit = din[3];
        endcase
    end

    assign valid = (state_q == GRANT);
    assign owner = owner_q;
    assign gnt   = valid ? dec : 4'b0000;
    assign dout  = valid & sel_bit;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one instance at MAXHOLD=8, one at MAXHOLD=3.
module tb_rr_arbiter4;

    logic       clk;
    logic       reset;
    logic [3:0] req,  din;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       valid, dout;
    logic [3:0] req3, din3;
    logic [3:0] gnt3;
    logic [1:0] owner3;
    logic       valid3, dout3;

    int checks = 0;
    int errors = 0;

    rr_arbiter4 #(.MAXHOLD(8)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .owner (owner),
        .valid (valid),
        .dout  (dout)
    );

    rr_arbiter4 #(.MAXHOLD(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .req   (req3),
        .din   (din3),
        .gnt   (gnt3),
        .owner (owner3),
        .valid (valid3),
        .dout  (dout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq3 [12];

    initial begin
        seq3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
        reset = 1'b0;
        req   = '0;
        din   = '0;
        req3  = '0;
        din3  = '0;
        tick();
        tick();
        chk("reset_gnt",   8'(gnt),   8'h0);
        chk("reset_valid", 8'(valid), 8'h0);
        chk("reset_dout",  8'(dout),  8'h0);
        chk("reset_gnt3",  8'(gnt3),  8'h0);

        // MAXHOLD=3 with two persistent requesters from reset
        req3  = 4'b0011;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("hold3_gnt_%0d", i), 8'(gnt3), 8'(seq3[i]));
            chk($sformatf("hold3_valid_%0d", i), 8'(valid3), 8'h1);
        end
        req3 = '0;
        chk("idle_while_other", 8'(valid), 8'h0);

        // first request from idle, ptr=0 -> requester 1
        req = 4'b1010;
        tick();
        chk("t1_gnt",   8'(gnt),   8'h02);
        chk("t1_owner", 8'(owner), 8'h1);
        chk("t1_valid", 8'(valid), 8'h1);
        chk("t1_dout0", 8'(dout),  8'h0);
        din = 4'b0010;
        #1;
        chk("t1_dout1", 8'(dout),  8'h1);
        din = 4'b1101;
        #1;
        chk("t1_dout2", 8'(dout),  8'h0);

        // voluntary release, nobody else -> idle, ptr=2
        req = '0;
        tick();
        chk("t1_idle_valid", 8'(valid), 8'h0);
        chk("t1_idle_gnt",   8'(gnt),   8'h0);

        // sole requester held long enough for cnt to saturate
        req = 4'b0001;
        din = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("sole_gnt", 8'(gnt), 8'h01);
        end
        chk("sole_dout", 8'(dout), 8'h1);
        req = '0;
        tick();
        chk("sole_release", 8'(valid), 8'h0);

        // ptr=1: grant 2, then owner 2 drops with 0 and 3 waiting
        req = 4'b0100;
        tick();
        chk("t4_owner2", 8'(owner), 8'h2);
        req = 4'b1001;
        tick();
        chk("t4_owner3", 8'(owner), 8'h3);
        chk("t4_gnt3",   8'(gnt),   8'h08);
        req = 4'b0001;
        tick();
        chk("t4_owner0", 8'(owner), 8'h0);
        chk("t4_valid0", 8'(valid), 8'h1);

        // drop all while owner 0 -> idle; ptr becomes 1
        din = 4'b1111;
        req = '0;
        tick();
        chk("t5_gnt",   8'(gnt),   8'h0);
        chk("t5_valid", 8'(valid), 8'h0);
        chk("t5_dout",  8'(dout),  8'h0);
        req = 4'b1111;
        tick();
        chk("t5_owner", 8'(owner), 8'h1);
        chk("t5_gnt1",  8'(gnt),   8'h02);
        chk("t5_dout1", 8'(dout),  8'h1);

        // asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        chk("t6_gnt",   8'(gnt),   8'h0);
        chk("t6_valid", 8'(valid), 8'h0);
        chk("t6_dout",  8'(dout),  8'h0);
        req = 4'b1100;
        tick();
        chk("t6_held_valid", 8'(valid), 8'h0);
        reset = 1'b1;
        tick();
        chk("t6_owner", 8'(owner), 8'h2);
        chk("t6_gnt",   8'(gnt),   8'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
